// File: rtl/dt_pkg.sv
// Shared constants, FSM state type and pixel-geometry helper for the distance-map repacker.
// Optional build macro used by this slice: DT_REPACK_MAXDIST_EN.
package dt_pkg;
  localparam int IMG_W   = 128;
  localparam int PIX_AW  = 14;
  localparam int WORD_AW = 10;
  localparam int WORD_W  = 16;
  localparam int DIST_W  = 8;
  localparam int OBJ_W   = 15;
  localparam int COORD_W = 7;

  localparam logic [PIX_AW-1:0]  LAST_PIX = PIX_AW'(IMG_W * IMG_W - 1);
  localparam logic [OBJ_W-1:0]   OBJ_MAX  = OBJ_W'(IMG_W * IMG_W);
  localparam logic [COORD_W-1:0] EDGE_HI  = COORD_W'(IMG_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } dt_repack_state_t;

  function automatic logic is_border(input logic [PIX_AW-1:0] a);
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    row = a[PIX_AW-1:COORD_W];
    col = a[COORD_W-1:0];
    return (row == '0) || (row == EDGE_HI) || (col == '0) || (col == EDGE_HI);
  endfunction
endpackage

// File: rtl/dt_repack_if.sv
// Control, result-RAM read and bitmap write signals of the repacker.
// The max_dist signal exists only when DT_REPACK_MAXDIST_EN is defined.
interface dt_repack_if;
  import dt_pkg::*;

  logic                start;
  logic                busy;
  logic                done;
  logic                res_rd;
  logic [PIX_AW-1:0]   res_addr;
  logic [DIST_W-1:0]   res_di;
  logic                bmp_wr;
  logic [WORD_AW-1:0]  bmp_addr;
  logic [WORD_W-1:0]   bmp_do;
  logic                border_err;
  logic [OBJ_W-1:0]    obj_cnt;
`ifdef DT_REPACK_MAXDIST_EN
  logic [DIST_W-1:0]   max_dist;
`endif

  modport master (
    output start, res_di,
`ifdef DT_REPACK_MAXDIST_EN
    input  max_dist,
`endif
    input  busy, done, res_rd, res_addr, bmp_wr, bmp_addr, bmp_do, border_err, obj_cnt
  );

  modport slave (
    input  start, res_di,
`ifdef DT_REPACK_MAXDIST_EN
    output max_dist,
`endif
    output busy, done, res_rd, res_addr, bmp_wr, bmp_addr, bmp_do, border_err, obj_cnt
  );
endinterface

// File: rtl/dt_pack16.sv
// 16-bit MSB-first shift packer: every 16th valid bit emits the completed word with a one-cycle strobe.
// The output word is held between strobes.
module dt_pack16
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              bit_i,
  input  logic              valid_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_vld_o
);

  logic [WORD_W-1:0] sr_q;
  logic [WORD_W-1:0] sr_d;
  logic [3:0]        cnt_q;
  logic [WORD_W-1:0] word_q;
  logic              word_vld_q;

  assign sr_d = {sr_q[WORD_W-2:0], bit_i};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      word_vld_q <= 1'b0;
      if (clr_i) begin
        sr_q  <= '0;
        cnt_q <= '0;
      end else if (valid_i) begin
        sr_q  <= sr_d;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == 4'hF) begin
          word_q     <= sr_d;
          word_vld_q <= 1'b1;
        end
      end
    end
  end

  assign word_o     = word_q;
  assign word_vld_o = word_vld_q;

endmodule

// File: rtl/dt_repack.sv
// Scans the 128x128 distance map and repacks it as a 1-bpp bitmap, counting object pixels and border hits.
// Define DT_REPACK_MAXDIST_EN to also track the maximum sampled distance.
module dt_repack
  import dt_pkg::*;
#(
  parameter int unsigned THRESH = 0
)
(
  input  logic       clk,
  input  logic       reset,
  dt_repack_if.slave dt_if
);

  localparam logic [DIST_W-1:0] THR = DIST_W'(THRESH);

  dt_repack_state_t   state_q;
  logic [PIX_AW-1:0]  addr_q;
  logic [PIX_AW-1:0]  paddr_q;
  logic               rd_q;
  logic               vld_q;
  logic               busy_q;
  logic               done_q;
  logic [WORD_AW-1:0] bmp_addr_q;
  logic               border_q;
  logic [OBJ_W-1:0]   obj_q;
  logic [OBJ_W-1:0]   obj_d;
  logic               start_acc;
  logic               smp_bit;
  logic               word_vld;
  logic [WORD_W-1:0]  word;

  assign start_acc = (state_q == ST_IDLE) && dt_if.start;
  assign smp_bit   = vld_q && (dt_if.res_di > THR);
  assign obj_d     = (smp_bit && (obj_q != OBJ_MAX)) ? obj_q + 1'b1 : obj_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dt_if.start) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          addr_q <= addr_q + 1'b1;
          if (addr_q == LAST_PIX) begin
            rd_q    <= 1'b0;
            state_q <= ST_FLUSH;
          end
        end
        // Wait for the packer to emit the final word before signalling done.
        ST_FLUSH: begin
          if (word_vld) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read data lags the address by one cycle; vld_q/paddr_q tag each sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q      <= 1'b0;
      paddr_q    <= '0;
      bmp_addr_q <= '0;
      border_q   <= 1'b0;
      obj_q      <= '0;
    end else begin
      vld_q   <= rd_q;
      paddr_q <= addr_q;
      if (start_acc) begin
        border_q <= 1'b0;
        obj_q    <= '0;
      end else if (vld_q) begin
        obj_q <= obj_d;
        if (smp_bit && is_border(paddr_q)) border_q <= 1'b1;
        if (paddr_q[3:0] == 4'hF) bmp_addr_q <= paddr_q[PIX_AW-1:4];
      end
    end
  end

`ifdef DT_REPACK_MAXDIST_EN
  logic [DIST_W-1:0] max_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= '0;
    end else if (start_acc) begin
      max_q <= '0;
    end else if (vld_q && (dt_if.res_di > max_q)) begin
      max_q <= dt_if.res_di;
    end
  end

  assign dt_if.max_dist = max_q;
`endif

  dt_pack16 u_pack (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (start_acc),
    .bit_i      (smp_bit),
    .valid_i    (vld_q),
    .word_o     (word),
    .word_vld_o (word_vld)
  );

  assign dt_if.busy       = busy_q;
  assign dt_if.done       = done_q;
  assign dt_if.res_rd     = rd_q;
  assign dt_if.res_addr   = addr_q;
  assign dt_if.bmp_wr     = word_vld;
  assign dt_if.bmp_addr   = bmp_addr_q;
  assign dt_if.bmp_do     = word;
  assign dt_if.border_err = border_q;
  assign dt_if.obj_cnt    = obj_q;

endmodule

// File: tb/tb_dt_repack.sv
// Bench for dt_repack: two instances (THRESH=0 and THRESH=1) reading behavioural result RAMs,
// with bitmaps, counts and border flags compared against a pixel-level model of the map.
module tb_dt_repack;
  import dt_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dt_repack_if if0 ();
  dt_repack_if if1 ();

  dt_repack #(.THRESH(0)) dut0 (.clk(clk), .reset(reset), .dt_if(if0.slave));
  dt_repack #(.THRESH(1)) dut1 (.clk(clk), .reset(reset), .dt_if(if1.slave));

  logic [7:0]  map     [2][16384];
  logic [15:0] exp_w   [2][1024];
  int          exp_obj [2];
  bit          exp_bdr [2];
  int          exp_max [2];
  int          scan_id [2];

  // Result RAMs: one-cycle read latency
  always @(posedge clk) begin
    if (if0.res_rd) if0.res_di <= map[0][if0.res_addr];
    if (if1.res_rd) if1.res_di <= map[1][if1.res_addr];
  end

  logic [1:0]  m_wr, m_done, m_busy, m_start;
  logic [9:0]  m_addr [2];
  logic [15:0] m_do   [2];
  assign m_wr     = {if1.bmp_wr, if0.bmp_wr};
  assign m_done   = {if1.done, if0.done};
  assign m_busy   = {if1.busy, if0.busy};
  assign m_start  = {if1.start, if0.start};
  assign m_addr[0] = if0.bmp_addr;
  assign m_addr[1] = if1.bmp_addr;
  assign m_do[0]   = if0.bmp_do;
  assign m_do[1]   = if1.bmp_do;

  logic [15:0] got  [2][1024];
  int          tag  [2][1024];
  int nxt [2], wr_cnt [2], ord_err [2], done_cnt [2], done_cyc [2], last_wr [2], bd_err [2], hold_err [2];
  logic [15:0] prev_do [2];
  logic [9:0]  prev_addr [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        prev_do[d]   = '0;
        prev_addr[d] = '0;
      end else begin
        if (m_start[d] && !m_busy[d] && !m_done[d]) nxt[d] = 0;
        if (m_wr[d]) begin
          if (m_addr[d] != 10'(nxt[d])) ord_err[d]++;
          got[d][m_addr[d]] = m_do[d];
          tag[d][m_addr[d]] = scan_id[d];
          nxt[d]++;
          wr_cnt[d]++;
          last_wr[d] = cyc;
        end else if (m_do[d] != prev_do[d] || m_addr[d] != prev_addr[d]) begin
          hold_err[d]++;
        end
        if (m_done[d]) begin
          done_cnt[d]++;
          done_cyc[d] = cyc;
          if (m_busy[d]) bd_err[d]++;
        end
        prev_do[d]   = m_do[d];
        prev_addr[d] = m_addr[d];
      end
    end
  end

  // Pixel-level model: bit = dist > thr, MSB-first within each 16-pixel word
  function automatic void build_exp(input int d, input int thr);
    exp_obj[d] = 0;
    exp_bdr[d] = 1'b0;
    exp_max[d] = 0;
    for (int w = 0; w < 1024; w++) exp_w[d][w] = '0;
    for (int p = 0; p < 16384; p++) begin
      int r, c, v;
      v = int'(map[d][p]);
      r = p / 128;
      c = p % 128;
      if (v > exp_max[d]) exp_max[d] = v;
      if (v > thr) begin
        exp_w[d][p / 16][15 - (p % 16)] = 1'b1;
        exp_obj[d]++;
        if (r == 0 || r == 127 || c == 0 || c == 127) exp_bdr[d] = 1'b1;
      end
    end
  endfunction

  function automatic int count_bad(input int d);
    int n = 0;
    for (int w = 0; w < 1024; w++)
      if (tag[d][w] != scan_id[d] || got[d][w] !== exp_w[d][w]) n++;
    return n;
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 0) if0.start = v;
    else        if1.start = v;
  endtask

  task automatic pulse_start(input int d, output int s);
    @(posedge clk); #1;
    set_start(d, 1'b1);
    s = cyc;
    @(posedge clk); #1;
    set_start(d, 1'b0);
  endtask

  task automatic wait_done(input int d, input int base, output bit to);
    to = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (done_cnt[d] != base) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_cycle(input int c);
    do begin
      @(posedge clk); #1;
    end while (cyc < c);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    checks++;
    if ({if0.busy, if0.done, if0.res_rd, if0.bmp_wr, if0.border_err} !== 5'b0 ||
        if0.res_addr !== '0 || if0.bmp_addr !== '0 || if0.bmp_do !== '0 || if0.obj_cnt !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b rd=%b wr=%b bdr=%b addr=%0d baddr=%0d do=%h obj=%0d, required all 0",
               if0.busy, if0.done, if0.res_rd, if0.bmp_wr, if0.border_err, if0.res_addr, if0.bmp_addr, if0.bmp_do, if0.obj_cnt);
    end
`ifdef DT_REPACK_MAXDIST_EN
    checks++;
    if (if0.max_dist !== '0) begin
      errors++;
      $display("FAIL reset_max_dist: got %0d, required 0", if0.max_dist);
    end
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Single object pixel at (1,2); start re-pulsed while busy and in the done cycle
  task automatic test_single_and_restart();
    int s, w0, d0, bad;
    bit to;
    for (int p = 0; p < 16384; p++) map[0][p] = 8'd0;
    map[0][130] = 8'd1;
    scan_id[0]++;
    build_exp(0, 0);
    w0 = wr_cnt[0];
    d0 = done_cnt[0];
    pulse_start(0, s);
    @(negedge clk);
    checks++;
    if (if0.busy !== 1'b1 || if0.res_rd !== 1'b1 || if0.res_addr !== 14'd0) begin
      errors++;
      $display("FAIL first_cycle: busy=%b rd=%b addr=%0d, required 1 1 0", if0.busy, if0.res_rd, if0.res_addr);
    end
    wait_cycle(s + 100);
    set_start(0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    wait_cycle(s + 16387);
    set_start(0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    wait_done(0, d0, to);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout: no done within budget"); end
    checks++;
    if (done_cnt[0] - d0 != 1) begin errors++; $display("FAIL single_done_count: got %0d, required 1", done_cnt[0] - d0); end
    checks++;
    if (done_cyc[0] - s != 16387) begin errors++; $display("FAIL done_cycle: got %0d, required 16387", done_cyc[0] - s); end
    checks++;
    if (last_wr[0] - s != 16386) begin errors++; $display("FAIL last_wr_cycle: got %0d, required 16386", last_wr[0] - s); end
    checks++;
    if (wr_cnt[0] - w0 != 1024) begin errors++; $display("FAIL single_writes: got %0d, required 1024", wr_cnt[0] - w0); end
    checks++;
    if (ord_err[0] != 0) begin errors++; $display("FAIL write_order: got %0d out-of-order, required 0", ord_err[0]); end
    bad = count_bad(0);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_bitmap: got %0d bad words, required 0", bad); end
    checks++;
    if (got[0][8] !== 16'h2000) begin errors++; $display("FAIL single_word8: got %h, required 2000", got[0][8]); end
    checks++;
    if (int'(if0.obj_cnt) != exp_obj[0]) begin errors++; $display("FAIL single_obj: got %0d, required %0d", if0.obj_cnt, exp_obj[0]); end
    checks++;
    if (if0.border_err !== exp_bdr[0]) begin errors++; $display("FAIL single_border: got %b, required %b", if0.border_err, exp_bdr[0]); end
    checks++;
    if (if0.busy !== 1'b0) begin errors++; $display("FAIL restart_ignored: busy=%b after done, required 0", if0.busy); end
    checks++;
    if (bd_err[0] != 0 || hold_err[0] != 0) begin
      errors++;
      $display("FAIL done_busy_hold: busy-in-done=%0d hold-violations=%0d, required 0 0", bd_err[0], hold_err[0]);
    end
  endtask

  task automatic test_ramp();
    int s, w0, d0, bad;
    bit to;
    for (int p = 0; p < 16384; p++) map[0][p] = 8'(p);
    scan_id[0]++;
    build_exp(0, 0);
    w0 = wr_cnt[0];
    d0 = done_cnt[0];
    pulse_start(0, s);
    wait_done(0, d0, to);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (to || wr_cnt[0] - w0 != 1024) begin errors++; $display("FAIL ramp_writes: timeout=%b writes=%0d, required 0 1024", to, wr_cnt[0] - w0); end
    bad = count_bad(0);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ramp_bitmap: got %0d bad words, required 0", bad); end
    checks++;
    if (got[0][0] !== 16'h7FFF) begin errors++; $display("FAIL ramp_word0: got %h, required 7fff", got[0][0]); end
    checks++;
    if (if0.obj_cnt !== 15'd16320) begin errors++; $display("FAIL ramp_obj: got %0d, required 16320", if0.obj_cnt); end
    checks++;
    if (if0.border_err !== 1'b1) begin errors++; $display("FAIL ramp_border: got %b, required 1", if0.border_err); end
`ifdef DT_REPACK_MAXDIST_EN
    checks++;
    if (int'(if0.max_dist) != exp_max[0]) begin errors++; $display("FAIL ramp_max: got %0d, required %0d", if0.max_dist, exp_max[0]); end
`endif
  endtask

  task automatic test_diamond();
    int s, w0, d0, bad;
    bit to;
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++) begin
        int v;
        v = 100 - ((r > 64 ? r - 64 : 64 - r) + (c > 64 ? c - 64 : 64 - c));
        map[1][r * 128 + c] = 8'(v < 0 ? 0 : v);
      end
    scan_id[1]++;
    build_exp(1, 1);
    w0 = wr_cnt[1];
    d0 = done_cnt[1];
    pulse_start(1, s);
    wait_done(1, d0, to);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (to || wr_cnt[1] - w0 != 1024 || ord_err[1] != 0) begin
      errors++;
      $display("FAIL diamond_writes: timeout=%b writes=%0d order=%0d, required 0 1024 0", to, wr_cnt[1] - w0, ord_err[1]);
    end
    bad = count_bad(1);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL diamond_bitmap: got %0d bad words, required 0", bad); end
    checks++;
    if (int'(if1.obj_cnt) != exp_obj[1]) begin errors++; $display("FAIL diamond_obj: got %0d, required %0d", if1.obj_cnt, exp_obj[1]); end
    checks++;
    if (if1.border_err !== exp_bdr[1]) begin errors++; $display("FAIL diamond_border: got %b, required %b", if1.border_err, exp_bdr[1]); end
  endtask

  task automatic test_reset_mid_scan();
    int s, w0, d0, wr_rst, dn_rst, bad;
    bit to;
    for (int p = 0; p < 16384; p++) map[0][p] = 8'($urandom_range(0, 2));
    for (int p = 0; p < 128; p++) map[0][p] = 8'd0;
    scan_id[0]++;
    build_exp(0, 0);
    pulse_start(0, s);
    wait_cycle(s + 5000);
    reset = 1'b1;
    #1;
    checks++;
    if ({if0.busy, if0.done, if0.res_rd, if0.bmp_wr, if0.border_err} !== 5'b0 ||
        if0.res_addr !== '0 || if0.bmp_addr !== '0 || if0.bmp_do !== '0 || if0.obj_cnt !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b done=%b rd=%b wr=%b bdr=%b addr=%0d do=%h obj=%0d, required all 0",
               if0.busy, if0.done, if0.res_rd, if0.bmp_wr, if0.border_err, if0.res_addr, if0.bmp_do, if0.obj_cnt);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wr_rst = wr_cnt[0];
    dn_rst = done_cnt[0];
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt[0] != wr_rst || done_cnt[0] != dn_rst || if0.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort: extra writes=%0d extra done=%0d busy=%b, required 0 0 0",
               wr_cnt[0] - wr_rst, done_cnt[0] - dn_rst, if0.busy);
    end
    scan_id[0]++;
    w0 = wr_cnt[0];
    d0 = done_cnt[0];
    pulse_start(0, s);
    wait_done(0, d0, to);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (to || wr_cnt[0] - w0 != 1024) begin errors++; $display("FAIL rescan_writes: timeout=%b writes=%0d, required 0 1024", to, wr_cnt[0] - w0); end
    bad = count_bad(0);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rescan_bitmap: got %0d bad words, required 0", bad); end
    checks++;
    if (int'(if0.obj_cnt) != exp_obj[0] || if0.border_err !== exp_bdr[0]) begin
      errors++;
      $display("FAIL rescan_counts: obj=%0d border=%b, required %0d %b", if0.obj_cnt, if0.border_err, exp_obj[0], exp_bdr[0]);
    end
  endtask

  initial begin
    if0.start = 1'b0;
    if1.start = 1'b0;
    test_reset();
    test_single_and_restart();
    fork
      test_ramp();
      test_diamond();
    join
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
